// File: rtl/store_buffer_pkg.sv
// Shared sizing and entry layout for the posted-write store buffer.
// Entry layout is {pc[31:0], be[3:0], data[31:0], addr[31:2]}, MSB first.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  be;
    logic [31:0] data;
    logic [29:0] addr;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_merge.sv
// Byte-lane store-to-load forwarding over the pending entries.
// Entries are walked oldest to youngest, so the youngest matching writer of a lane wins.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [PTR_W-1:0]   head,
  input  logic [29:0]        ld_word,
  output logic [3:0]         fwd_be,
  output logic [31:0]        fwd_d
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_d;

      always_comb begin
        logic [PTR_W-1:0] idx;
        lane_hit = 1'b0;
        lane_d   = 8'h00;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx = head + PTR_W'(k);
          if (valid[idx] && entries[idx].addr == ld_word && entries[idx].be[gi]) begin
            lane_hit = 1'b1;
            lane_d   = entries[idx].data[8*gi +: 8];
          end
        end
      end

      assign fwd_be[gi]       = lane_hit;
      assign fwd_d[8*gi +: 8] = lane_d;
    end
  endgenerate
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM-stage store path and data memory,
// with byte-wise forwarding from pending entries to the load path.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_pc,
  input  logic [31:0]      ld_addr,
  output logic [3:0]       ld_fwd_be,
  output logic [31:0]      ld_fwd_d,
  output logic             dm_we,
  input  logic             dm_ready,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_pc,
  output logic [PTR_W:0]   count,
  output logic             empty
);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic             push;
  logic             pop;
  sb_entry_t        head_entry;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign count    = count_reg;
  assign empty    = (count_reg == '0);
  assign st_ready = (count_reg != FULL_COUNT);
  assign dm_we    = !empty;
  assign push     = st_valid && st_ready;
  assign pop      = dm_we && dm_ready;

  // Storage carries no reset; the valid mask alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= '{pc: st_pc, be: st_be, data: st_data, addr: st_addr[31:2]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (pop) begin
        head_reg            <= head_reg + 1'b1;
        valid_reg[head_reg] <= 1'b0;
      end
      if (push) begin
        tail_reg            <= tail_reg + 1'b1;
        valid_reg[tail_reg] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head fields read as zero while empty so stale storage never reaches the DM port.
  assign head_entry = mem[head_reg];
  assign dm_addr    = dm_we ? {head_entry.addr, 2'b00} : 32'h0;
  assign dm_wd      = dm_we ? head_entry.data : 32'h0;
  assign dm_be      = dm_we ? head_entry.be : 4'h0;
  assign dm_pc      = dm_we ? head_entry.pc : 32'h0;

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries (mem),
    .valid   (valid_reg),
    .head    (head_reg),
    .ld_word (ld_addr[31:2]),
    .fwd_be  (ld_fwd_be),
    .fwd_d   (ld_fwd_d)
  );
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_d;
  logic        dm_we;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] dm_log[$];

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .st_pc     (st_pc),
    .ld_addr   (ld_addr),
    .ld_fwd_be (ld_fwd_be),
    .ld_fwd_d  (ld_fwd_d),
    .dm_we     (dm_we),
    .dm_ready  (dm_ready),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_be     (dm_be),
    .dm_pc     (dm_pc),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference forwarding: scan pending stores oldest->youngest, later writers overwrite lanes.
  function automatic void model_fwd(input logic [31:0] la, output logic [3:0] be,
                                    output logic [31:0] d);
    be = 4'h0;
    d  = 32'h0;
    foreach (q[k]) begin
      if (q[k].addr[31:2] == la[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[k].be[b]) begin
            be[b]       = 1'b1;
            d[8*b +: 8] = q[k].data[8*b +: 8];
          end
        end
      end
    end
  endfunction

  // Model state advances on each clock edge from the inputs that were stable before it.
  always @(posedge clk) begin
    if (!reset) begin
      bit do_pop;
      bit do_push;
      ent_t e;
      do_pop  = (q.size() > 0) && dm_ready;
      do_push = st_valid && (q.size() < DEPTH);
      e.addr = st_addr;
      e.data = st_data;
      e.be   = st_be;
      e.pc   = st_pc;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Per-cycle comparison against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      logic [3:0]  exp_be;
      logic [31:0] exp_d;
      bit          ne;
      ne = (q.size() > 0);
      model_fwd(ld_addr, exp_be, exp_d);
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(!ne));
      chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
      chk("dm_we", 32'(dm_we), 32'(ne));
      chk("dm_addr", dm_addr, ne ? {q[0].addr[31:2], 2'b00} : 32'h0);
      chk("dm_wd", dm_wd, ne ? q[0].data : 32'h0);
      chk("dm_be", 32'(dm_be), ne ? 32'(q[0].be) : 32'h0);
      chk("dm_pc", dm_pc, ne ? q[0].pc : 32'h0);
      chk("ld_fwd_be", 32'(ld_fwd_be), 32'(exp_be));
      chk("ld_fwd_d", ld_fwd_d, exp_d);
      if (dm_we && dm_ready) dm_log.push_back(dm_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(bit v, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = 32'h1000 + a;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    dm_ready = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) step();
    chk("drain_empty", 32'(empty), 32'h1);
    dm_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  mbe;
    logic [31:0] md;
    int          sent;
    int          nlog;

    reset    = 1'b1;
    dm_ready = 1'b0;
    ld_addr  = 32'h0;
    set_store(1'b0, 32'h0, 32'h0, 4'h0);
    #12 reset = 1'b0;
    #1;

    // 1: reset state, then four stores with DM stalled
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    chk("rst_fwd_be", 32'(ld_fwd_be), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
      step();
    end
    st_valid = 1'b0;
    chk("t1_count", 32'(count), 32'h4);
    chk("t1_st_ready", 32'(st_ready), 32'h0);
    chk("t1_dm_addr", dm_addr, 32'h100);
    chk("t1_dm_we", 32'(dm_we), 32'h1);
    $display("test 1: four stores queued, count=%0d", count);

    // 2: full buffer, pop and store in the same cycle
    set_store(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF);
    dm_ready = 1'b1;
    step();
    chk("t2_count_pop", 32'(count), 32'h3);
    chk("t2_dm_addr", dm_addr, 32'h104);
    dm_ready = 1'b0;
    step();
    chk("t2_count_push", 32'(count), 32'h4);
    st_valid = 1'b0;
    drain();
    $display("test 2: store held off while full, accepted next cycle");

    // 3: youngest writer wins per lane
    set_store(1'b1, 32'h10, 32'h1122_3344, 4'hF);
    step();
    set_store(1'b1, 32'h12, 32'h00AA_0000, 4'h4);
    step();
    st_valid = 1'b0;
    ld_addr  = 32'h10;
    #1;
    model_fwd(32'h10, mbe, md);
    chk("t3_model_d", md, 32'h11AA_3344);
    chk("t3_fwd_be", 32'(ld_fwd_be), 32'hF);
    chk("t3_fwd_d", ld_fwd_d, 32'h11AA_3344);
    drain();
    $display("test 3: forwarded %h", 32'h11AA_3344);

    // 4: partial forwarding and a miss on the neighbouring word
    set_store(1'b1, 32'h20, 32'h0000_BEEF, 4'h3);
    step();
    st_valid = 1'b0;
    ld_addr  = 32'h20;
    #1;
    chk("t4_fwd_be", 32'(ld_fwd_be), 32'h3);
    chk("t4_fwd_d", ld_fwd_d, 32'h0000_BEEF);
    ld_addr = 32'h24;
    #1;
    chk("t4_miss_be", 32'(ld_fwd_be), 32'h0);
    chk("t4_miss_d", ld_fwd_d, 32'h0);
    drain();
    $display("test 4: partial forward checked");

    // 5: ten stores through the ring with DM ready toggling
    dm_log.delete();
    sent = 0;
    for (int c = 0; c < 200 && !(sent == 10 && empty); c++) begin
      bit acc;
      dm_ready = (c % 2 == 1);
      if (sent < 10) set_store(1'b1, 32'(sent * 4), 32'h5000 + 32'(sent), 4'hF);
      else st_valid = 1'b0;
      acc = st_valid && st_ready;
      step();
      if (acc) sent++;
    end
    st_valid = 1'b0;
    dm_ready = 1'b0;
    chk("t5_writes", 32'(dm_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < dm_log.size(); i++) chk("t5_order", dm_log[i], 32'(i * 4));
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_empty", 32'(empty), 32'h1);
    $display("test 5: %0d writes drained in order", dm_log.size());

    // 6: asynchronous reset between edges with entries pending
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h300 + 32'(i * 4), 32'h77 + 32'(i), 4'hF);
      step();
    end
    st_valid = 1'b0;
    dm_ready = 1'b1;
    #1 reset = 1'b1;
    q.delete();
    #1;
    chk("t6_dm_we", 32'(dm_we), 32'h0);
    chk("t6_empty", 32'(empty), 32'h1);
    chk("t6_st_ready", 32'(st_ready), 32'h1);
    chk("t6_count", 32'(count), 32'h0);
    #1 reset = 1'b0;
    nlog = dm_log.size();
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_writes", 32'(dm_log.size()), 32'(nlog));
    $display("test 6: reset discarded pending stores");

    // Randomized traffic over a small address window to provoke forwarding hits
    for (int c = 0; c < 1500; c++) begin
      set_store($urandom_range(0, 1) == 1,
                32'h40 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)));
      st_pc    = $urandom;
      dm_ready = ($urandom_range(0, 2) != 0);
      ld_addr  = 32'h40 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        q.delete();
        #1 reset = 1'b0;
      end
      step();
    end
    $display("random phase: 1500 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
